aud_sample_feeder: RTL and testbench
====================================

// Module: aud_sample_feeder
// PURPOSE
//  APB slave holding a small PCM sample FIFO and a sample-rate pacer.
//  Software pushes samples over APB. The pacer releases one sample per period
//  through a valid/ready stream to the downstream aud_pwm modulator.
//  Sits directly upstream of the PWM stage on the APB peripheral bus, so PWM
//  playback is driven by software-supplied audio rather than a fixed pattern.
// PARAMETERS
//  SAMPLE_W    8   sample width in bits (1..16)
//  FIFO_DEPTH  16  FIFO entries; power of two, >= 2
//  DIV_W       16  width of sample-period divider register
// PORTS
//  pclk_i          in   1         sole clock
//  presetn_i       in   1         asynchronous active-low reset
//  paddr_i         in   32        APB address (byte)
//  psel_i          in   1         APB select
//  penable_i       in   1         APB enable (access phase)
//  pwrite_i        in   1         APB write
//  pwdata_i        in   32        APB write data
//  pready_o        out  1         APB ready, tied 1 (zero wait states)
//  prdata_o        out  32        APB read data
//  pslverr_o       out  1         APB error, valid when psel_i & penable_i
//  sample_o        out  SAMPLE_W  sample to PWM stage
//  sample_valid_o  out  1         sample_o valid
//  sample_ready_i  in   1         PWM stage accepts sample
//  underrun_irq_o  out  1         level IRQ: STATUS.UNDERRUN & CTRL.IRQ_EN
// BEHAVIOUR
//  Reset: every register, FIFO pointer and output is 0; pready_o = 1; state = IDLE.
//  Access: an access completes in the cycle where psel_i & penable_i.
//   Writes take effect at that clock edge.
//   prdata_o is combinational from the addressed register; it is 0 when not reading.
//  Register map:
//   0x00 CTRL RW    [0] EN, [1] FLUSH (write-1 pulse, reads 0), [2] IRQ_EN
//   0x04 DIV  RW    [DIV_W-1:0] sample period minus 1, in pclk cycles
//   0x08 DATA WO    a write pushes pwdata_i[SAMPLE_W-1:0] into the FIFO
//   0x0C STAT RO/W1C  [7:0] LEVEL, [8] EMPTY, [9] FULL, [10] UNDERRUN (W1C)
//  pslverr_o = 1 (no register change) for any of:
//   - paddr_i > 0x0C
//   - paddr_i[1:0] != 0
//   - a read of DATA
//   - a DATA write while FULL and no pop occurs in the same cycle; the sample is dropped
//  FIFO: push and pop in the same cycle both occur and LEVEL is unchanged.
//   This includes the case where the FIFO is FULL.
//   Pointers wrap modulo FIFO_DEPTH. LEVEL ranges 0..FIFO_DEPTH.
//  Pacer counter cnt (DIV_W bits):
//   - loads DIV when EN = 0
//   - with EN = 1, it decrements each cycle; at cnt == 0 it reloads DIV and asserts a tick for 1 cycle
//   - tick period = DIV + 1 cycles; DIV = 0 gives a tick every cycle
//   - a DIV write takes effect at the next reload
//  FSM:
//   IDLE: EN = 0. valid = 0. Goes to WAIT when EN = 1.
//   WAIT: on a tick with FIFO non-empty -> pop the head into sample_o, go to PRESENT.
//         On a tick with FIFO empty -> set UNDERRUN, hold sample_o, stay in WAIT.
//         EN = 0 -> go to IDLE.
//   PRESENT: sample_valid_o = 1, sample_o stable until sample_ready_i.
//         On the handshake go to WAIT, or to IDLE if EN = 0.
//         Ticks in PRESENT are discarded; they do not set UNDERRUN.
//   Latency: a tick at edge k gives sample_valid_o = 1 after edge k (a registered pop).
//  Clearing EN mid-operation: the counter reloads. A PRESENT sample is held until it is accepted.
//  FLUSH: empties the FIFO (LEVEL = 0). It does not affect PRESENT, sample_o or UNDERRUN.
//   If FLUSH and a DATA push fall in the same cycle, the FLUSH wins.
//  UNDERRUN W1C together with a same-cycle new underrun: set wins.
//  Reset asserted mid-operation: everything returns immediately to its reset values.
// TESTING
//  1. Reset, then read STAT -> 0x100 (EMPTY). CTRL = DIV = 0. underrun_irq_o = 0. pready_o = 1.
//  2. Write DIV = 3, push 0x11, 0x22, 0x33, set EN, ready = 1
//     -> samples 0x11, 0x22, 0x33 each valid for 1 cycle, spaced 4 cycles apart.
//  3. Push FIFO_DEPTH + 1 samples with EN = 0 -> the last push returns pslverr.
//     STAT = FULL, LEVEL = 16.
//  4. EN = 1, FIFO empty, IRQ_EN = 1 -> UNDERRUN = 1 and underrun_irq_o = 1 after the first tick.
//     Write STAT 0x400 -> cleared.
//  5. Hold sample_ready_i = 0 across 3 ticks
//     -> sample_o is held, no pop occurs, no UNDERRUN. After ready, the next sample follows the next tick.
//  6. Reads at 0x10, at 0x02, and of DATA -> pslverr = 1.
//     FLUSH with 5 queued -> LEVEL = 0, with the PRESENT sample intact.

Source files
------------

// File: rtl/aud_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : aud_sample_feeder
//  Description : APB slave with a PCM sample FIFO and a sample-rate pacer.
//                Software pushes samples over APB; the pacer releases one
//                sample per period through a valid/ready stream towards the
//                downstream PWM modulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_sample_feeder #(
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                pclk_i,
  input  logic                presetn_i,
  input  logic [31:0]         paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [31:0]         pwdata_i,
  output logic                pready_o,
  output logic [31:0]         prdata_o,
  output logic                pslverr_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                underrun_irq_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] C_REG_CTRL = 2'd0;
  localparam logic [1:0] C_REG_DIV  = 2'd1;
  localparam logic [1:0] C_REG_DATA = 2'd2;
  localparam logic [1:0] C_REG_STAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Register state
  logic                r_en;
  logic                r_irq_en;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_cnt;
  logic                r_underrun;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  state_t              r_state;
  state_t              w_state_nxt;

  // Decoded bus access
  logic       w_access;
  logic       w_wr;
  logic       w_rd;
  logic       w_addr_ok;
  logic [1:0] w_reg;
  logic       w_empty;
  logic       w_full;
  logic       w_tick;
  logic       w_pop;
  logic       w_push;
  logic       w_flush;
  logic       w_drop;
  logic       w_underrun_set;
  logic       w_underrun_clr;
  logic       w_valid;
  logic [7:0] w_level8;
  logic       unused_bits;

  assign w_access  = psel_i & penable_i;
  assign w_wr      = w_access & pwrite_i;
  assign w_rd      = w_access & ~pwrite_i;
  assign w_addr_ok = (paddr_i <= 32'h0000_000C) && (paddr_i[1:0] == 2'b00);
  assign w_reg     = paddr_i[3:2];

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_level8 = 8'(r_level);

  // FLUSH outranks any push in the same cycle.
  assign w_flush = w_wr & w_addr_ok & (w_reg == C_REG_CTRL) & pwdata_i[1];

  // A full FIFO still accepts a push when the pacer pops in the same cycle.
  assign w_drop = w_wr & w_addr_ok & (w_reg == C_REG_DATA) & w_full & ~w_pop;
  assign w_push = w_wr & w_addr_ok & (w_reg == C_REG_DATA) & ~w_drop & ~w_flush;

  assign w_underrun_clr = w_wr & w_addr_ok & (w_reg == C_REG_STAT) & pwdata_i[10];

  assign pready_o       = 1'b1;
  assign pslverr_o      = w_access & (~w_addr_ok
                                      | (w_rd & (w_reg == C_REG_DATA))
                                      | w_drop);
  assign sample_o       = r_sample;
  assign sample_valid_o = w_valid;
  assign underrun_irq_o = r_underrun & r_irq_en;

  // Write-data bits with no register behind them are folded here.
  assign unused_bits = ^pwdata_i;

  // Pacer tick fires on the cycle the counter sits at zero while enabled.
  assign w_tick = r_en & (r_cnt == '0);

  // Control/divider registers written from the bus.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_div    <= '0;
    end else if (w_wr && w_addr_ok) begin
      if (w_reg == C_REG_CTRL) begin
        r_en     <= pwdata_i[0];
        r_irq_en <= pwdata_i[2];
      end
      if (w_reg == C_REG_DIV) begin
        r_div <= pwdata_i[DIV_W-1:0];
      end
    end
  end

  // Sample-period counter: parked at DIV when disabled, otherwise counts down.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_cnt <= '0;
    end else if (!r_en || r_cnt == '0) begin
      r_cnt <= r_div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Sticky underrun flag; a new underrun beats a same-cycle clear.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end else if (w_underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  // FIFO storage, pointers and fill level.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= pwdata_i[SAMPLE_W-1:0];
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_level  <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_level <= r_level + 1'b1;
        end else if (w_pop && !w_push) begin
          r_level <= r_level - 1'b1;
        end
      end
    end
  end

  // Output sample register, loaded only on a pop so it holds otherwise.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_sample <= '0;
    end else if (w_pop) begin
      r_sample <= r_mem[r_rd_ptr];
    end
  end

  // Playback state register.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Playback next-state and stream control. IDLE with EN already set acts
  // like WAIT so a tick arriving on the first enabled cycle (DIV = 0) is kept.
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_underrun_set = 1'b0;
    w_valid        = 1'b0;
    case (r_state)
      ST_IDLE, ST_WAIT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
          if (w_tick) begin
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = ST_PRESENT;
            end else begin
              w_underrun_set = 1'b1;
            end
          end
        end
      end
      ST_PRESENT: begin
        w_valid = 1'b1;
        if (sample_ready_i) begin
          w_state_nxt = r_en ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read mux: combinational, zero outside a valid register read.
  always_comb begin
    prdata_o = '0;
    if (w_rd && w_addr_ok) begin
      case (w_reg)
        C_REG_CTRL: prdata_o = {29'd0, r_irq_en, 1'b0, r_en};
        C_REG_DIV:  prdata_o[DIV_W-1:0] = r_div;
        C_REG_STAT: prdata_o = {21'd0, r_underrun, w_full, w_empty, w_level8};
        default:    prdata_o = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aud_sample_feeder
//  Description : Directed self-checking bench for aud_sample_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_sample_feeder;

  logic        clk = 1'b0;
  logic        presetn;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        underrun_irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int vcnt  = 0;
  logic [7:0] hs_val[$];
  int         hs_cyc[$];

  aud_sample_feeder #(
    .SAMPLE_W  (8),
    .FIFO_DEPTH(16),
    .DIV_W     (16)
  ) dut (
    .pclk_i        (clk),
    .presetn_i     (presetn),
    .paddr_i       (paddr),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .pwdata_i      (pwdata),
    .pready_o      (pready),
    .prdata_o      (prdata),
    .pslverr_o     (pslverr),
    .sample_o      (sample),
    .sample_valid_o(sample_valid),
    .sample_ready_i(sample_ready),
    .underrun_irq_o(underrun_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: counts valid cycles and logs every handshake mid-cycle.
  always @(negedge clk) begin
    if (presetn && sample_valid) begin
      vcnt = vcnt + 1;
      if (sample_ready) begin
        hs_val.push_back(sample);
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d   = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_hs(input int need, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (hs_val.size() >= need) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    bit          ok;
    int          base;
    int          v0;
    int          errs;
    int          gap;

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 presetn = 1'b1;

    // 1. Reset state
    apb_read(32'h0C, rd, err); check_val("rst_stat", rd, 32'h100);
    apb_read(32'h00, rd, err); check_val("rst_ctrl", rd, 32'h0);
    apb_read(32'h04, rd, err); check_val("rst_div", rd, 32'h0);
    check_val("rst_irq", underrun_irq, 1'b0);
    check_val("rst_pready", pready, 1'b1);
    check_val("rst_valid", sample_valid, 1'b0);

    // 2. Three samples paced 4 cycles apart
    apb_write(32'h04, 32'd3, err);
    apb_read(32'h04, rd, err); check_val("t2_div_rb", rd, 32'd3);
    apb_write(32'h08, 32'h11, err);
    apb_write(32'h08, 32'h22, err);
    apb_write(32'h08, 32'h33, err);
    apb_read(32'h0C, rd, err); check_val("t2_level3", rd, 32'h003);
    sample_ready = 1'b1;
    base = hs_val.size();
    v0   = vcnt;
    apb_write(32'h00, 32'h1, err);
    wait_hs(base + 3, 60, ok);
    check_val("t2_timeout", ok, 1'b1);
    if (ok) begin
      check_val("t2_s0", hs_val[base],     8'h11);
      check_val("t2_s1", hs_val[base + 1], 8'h22);
      check_val("t2_s2", hs_val[base + 2], 8'h33);
      check_val("t2_gap01", hs_cyc[base + 1] - hs_cyc[base],     4);
      check_val("t2_gap12", hs_cyc[base + 2] - hs_cyc[base + 1], 4);
    end
    apb_write(32'h00, 32'h0, err);
    check_val("t2_valid_cycles", vcnt - v0, 3);
    apb_write(32'h0C, 32'h400, err);
    apb_read(32'h0C, rd, err); check_val("t2_stat_end", rd, 32'h100);

    // 3. Overfill with EN = 0
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      apb_write(32'h08, 32'h40 + i, err);
      if (err) errs++;
    end
    check_val("t3_push_err_cnt", errs, 0);
    apb_write(32'h08, 32'hEE, err); check_val("t3_overflow_err", err, 1'b1);
    apb_read(32'h0C, rd, err); check_val("t3_stat_full", rd, 32'h210);
    apb_write(32'h00, 32'h2, err);
    apb_read(32'h0C, rd, err); check_val("t3_stat_flushed", rd, 32'h100);
    apb_read(32'h00, rd, err); check_val("t3_ctrl_flush_rd0", rd, 32'h0);

    // 4. Underrun and IRQ
    v0 = vcnt;
    apb_write(32'h00, 32'h5, err);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (underrun_irq) begin ok = 1'b1; break; end
    end
    check_val("t4_irq", ok, 1'b1);
    apb_read(32'h0C, rd, err); check_val("t4_stat_underrun", rd, 32'h500);
    apb_write(32'h00, 32'h4, err);
    apb_write(32'h0C, 32'h400, err);
    apb_read(32'h0C, rd, err); check_val("t4_stat_cleared", rd, 32'h100);
    check_val("t4_irq_low", underrun_irq, 1'b0);
    check_val("t4_no_valid", vcnt - v0, 0);
    apb_write(32'h00, 32'h0, err);

    // 5. Back-pressure across several ticks
    sample_ready = 1'b0;
    apb_write(32'h08, 32'hA1, err);
    apb_write(32'h08, 32'hA2, err);
    base = hs_val.size();
    apb_write(32'h00, 32'h1, err);
    wait_valid(20, ok);
    check_val("t5_valid", ok, 1'b1);
    check_val("t5_sample", sample, 8'hA1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_val("t5_held_sample", sample, 8'hA1);
    check_val("t5_held_valid", sample_valid, 1'b1);
    apb_read(32'h0C, rd, err); check_val("t5_stat_nopop", rd, 32'h001);
    @(posedge clk); #1 sample_ready = 1'b1;
    wait_hs(base + 2, 20, ok);
    check_val("t5_timeout", ok, 1'b1);
    if (ok) begin
      check_val("t5_hs0", hs_val[base],     8'hA1);
      check_val("t5_hs1", hs_val[base + 1], 8'hA2);
      gap = hs_cyc[base + 1] - hs_cyc[base];
      check_val("t5_gap_ok", (gap >= 1 && gap <= 5), 1'b1);
    end
    apb_write(32'h00, 32'h0, err);
    apb_write(32'h0C, 32'h400, err);

    // 6. Bus errors and FLUSH with a PRESENT sample
    apb_read(32'h10, rd, err); check_val("t6_err_0x10", err, 1'b1);
    apb_read(32'h02, rd, err); check_val("t6_err_0x02", err, 1'b1);
    apb_read(32'h08, rd, err); check_val("t6_err_data", err, 1'b1);
    check_val("t6_data_rd0", rd, 32'h0);
    apb_write(32'h04, 32'd9, err); check_val("t6_div_ok", err, 1'b0);
    sample_ready = 1'b0;
    apb_write(32'h08, 32'hB0, err);
    apb_write(32'h00, 32'h1, err);
    wait_valid(30, ok);
    check_val("t6_valid", ok, 1'b1);
    apb_write(32'h00, 32'h0, err);
    for (int i = 1; i <= 5; i++) apb_write(32'h08, 32'hB0 + i, err);
    apb_read(32'h0C, rd, err); check_val("t6_level5", rd, 32'h005);
    apb_write(32'h00, 32'h2, err);
    apb_read(32'h0C, rd, err); check_val("t6_flushed", rd, 32'h100);
    check_val("t6_present_valid", sample_valid, 1'b1);
    check_val("t6_present_sample", sample, 8'hB0);
    base = hs_val.size();
    @(posedge clk); #1 sample_ready = 1'b1;
    wait_hs(base + 1, 10, ok);
    check_val("t6_hs", ok, 1'b1);
    if (ok) check_val("t6_hs_val", hs_val[base], 8'hB0);

    // Reset mid-operation
    apb_write(32'h08, 32'h77, err);
    apb_write(32'h00, 32'h5, err);
    @(posedge clk); #1 presetn = 1'b0;
    @(posedge clk); #1 presetn = 1'b1;
    apb_read(32'h0C, rd, err); check_val("rst2_stat", rd, 32'h100);
    apb_read(32'h00, rd, err); check_val("rst2_ctrl", rd, 32'h0);
    apb_read(32'h04, rd, err); check_val("rst2_div", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
